// File: rtl/sbox_pkg.sv
// Shared constants for the word-serial AES S-box: composite-field basis changes,
// affine constant, FSM states and the byte-index width.
package sbox_pkg;

    localparam int IDX_W = 2;
    localparam logic [7:0] AFFINE_C = 8'h63;

    // Row j of a matrix multiplies input bit 7-j; bit i of the row feeds output bit i.
    typedef logic [0:7][7:0] gf_mat_t;

    localparam gf_mat_t A2X = {8'h98, 8'hF3, 8'hF2, 8'h48, 8'h09, 8'h81, 8'hA9, 8'hFF};
    localparam gf_mat_t X2A = {8'h64, 8'h78, 8'h6E, 8'h8C, 8'h68, 8'h29, 8'hDE, 8'h60};
    localparam gf_mat_t X2S = {8'h58, 8'h2D, 8'h9E, 8'h0B, 8'hDC, 8'h04, 8'h03, 8'h24};
    localparam gf_mat_t S2X = {8'h8C, 8'h79, 8'h05, 8'hEB, 8'h12, 8'h04, 8'h51, 8'h53};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] gf_mvm(input logic [7:0] v, input gf_mat_t m);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i] = r[i] ^ (m[j][i] & v[7-j]);
        return r;
    endfunction

endpackage

// File: rtl/gf_inv_8.sv
// GF(2^8) inverter in the normal-basis tower GF(((2^2)^2)^2); 0 maps to 0.
module gf_inv_8 (
    input  logic [7:0] x,
    output logic [7:0] y
);

    function automatic logic [1:0] mul2(input logic [1:0] g, input logic [1:0] d);
        logic a, b, c;
        a = g[1] & d[1];
        b = (^g) & (^d);
        c = g[0] & d[0];
        return {a ^ b, c ^ b};
    endfunction

    function automatic logic [1:0] sq2(input logic [1:0] g);
        return {g[0], g[1]};
    endfunction

    function automatic logic [1:0] scl_w2(input logic [1:0] g);
        return {g[0], g[1] ^ g[0]};
    endfunction

    function automatic logic [1:0] scl_w(input logic [1:0] g);
        return {g[1] ^ g[0], g[1]};
    endfunction

    function automatic logic [3:0] mul4(input logic [3:0] g, input logic [3:0] d);
        logic [1:0] a, b, c;
        a = mul2(g[3:2], d[3:2]);
        b = mul2(g[3:2] ^ g[1:0], d[3:2] ^ d[1:0]);
        c = mul2(g[1:0], d[1:0]);
        return {a ^ scl_w2(b), c ^ scl_w2(b)};
    endfunction

    function automatic logic [3:0] sq_scl4(input logic [3:0] g);
        return {sq2(g[3:2] ^ g[1:0]), scl_w(sq2(g[1:0]))};
    endfunction

    function automatic logic [3:0] inv4(input logic [3:0] g);
        logic [1:0] a, b, c, d;
        a = g[3:2] ^ g[1:0];
        b = mul2(g[3:2], g[1:0]);
        c = scl_w2(sq2(a));
        d = sq2(c ^ b);
        return {mul2(d, g[1:0]), mul2(d, g[3:2])};
    endfunction

    logic [3:0] sum_h, prod_h, inv_h;

    always_comb begin
        sum_h  = x[7:4] ^ x[3:0];
        prod_h = mul4(x[7:4], x[3:0]);
        inv_h  = inv4(sq_scl4(sum_h) ^ prod_h);
        y      = {mul4(inv_h, x[3:0]), mul4(inv_h, x[7:4])};
    end

endmodule

// File: rtl/sbox_word_serial.sv
// 32-bit AES forward/inverse SubBytes, one byte per cycle through a single
// shared composite-field datapath with an optional register after the inverter.
module sbox_word_serial
    import sbox_pkg::*;
#(
    parameter int REG_INV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word
);

    state_t           state, state_n;
    logic [IDX_W-1:0] cnt, wr_idx;
    logic [31:0]      word_q;
    logic             inv_q;
    logic [23:0]      res_q;
    logic             accept, busy, issue, wr_en;
    logic [7:0]       byte_in, x_in, x_inv, x_out, wr_byte;

    assign accept = in_valid & in_ready;
    assign busy   = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = BUSY;
            end
            BUSY: if (wr_en && wr_idx == '1) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_n  = in_valid ? BUSY : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            word_q <= '0;
            inv_q  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            word_q <= in_word;
            inv_q  <= in_inv;
        end else if (issue) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Inverse mode folds the inverse affine into the input basis change.
    assign byte_in = word_q[{cnt, 3'b000} +: 8];
    assign x_in    = inv_q ? gf_mvm(byte_in ^ AFFINE_C, S2X) : gf_mvm(byte_in, A2X);

    gf_inv_8 u_gf_inv (
        .x (x_in),
        .y (x_inv)
    );

    generate
        if (REG_INV != 0) begin : g_reg
            logic             vld_pipe;
            logic [IDX_W-1:0] idx_pipe;
            logic [7:0]       inv_pipe;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_pipe <= 1'b0;
                    idx_pipe <= '0;
                    inv_pipe <= '0;
                end else begin
                    vld_pipe <= issue;
                    if (issue) begin
                        idx_pipe <= cnt;
                        inv_pipe <= x_inv;
                    end
                end
            end

            // Stop feeding once byte 3 sits in the register; that cycle only drains.
            assign issue  = busy && !(vld_pipe && idx_pipe == '1);
            assign wr_en  = busy && vld_pipe;
            assign wr_idx = idx_pipe;
            assign x_out  = inv_pipe;
        end else begin : g_comb
            assign issue  = busy;
            assign wr_en  = busy;
            assign wr_idx = cnt;
            assign x_out  = x_inv;
        end
    endgenerate

    assign wr_byte = inv_q ? gf_mvm(x_out, X2A) : (gf_mvm(x_out, X2S) ^ AFFINE_C);

    // Bytes 0..2 collect in res_q so out_word only changes when the word completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q    <= '0;
            out_word <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 3; b++)
                if (wr_idx == b[IDX_W-1:0]) res_q[8*b +: 8] <= wr_byte;
            if (wr_idx == '1) out_word <= {wr_byte, res_q};
        end
    end

endmodule

// File: tb/tb_sbox_word_serial.sv
// Bench for sbox_word_serial: both REG_INV builds against an arithmetic AES S-box model.
module tb_sbox_word_serial;

    logic             clk = 1'b0;
    logic [1:0]       rst_n = 2'b00;
    logic [1:0]       in_valid = '0;
    logic [1:0]       in_inv = '0;
    logic [1:0]       out_ready = '0;
    logic [1:0][31:0] in_word = '0;
    wire  [1:0]       in_ready;
    wire  [1:0]       out_valid;
    wire  [1:0][31:0] out_word;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sbox_word_serial #(.REG_INV(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_word   (in_word[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_word  (out_word[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_model;
        logic [7:0] iv;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            sb[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m ? isb[w[8*k +: 8]] : sb[w[8*k +: 8]];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one word, returns the result and the accept-to-out_valid latency.
    task automatic run_word(input int d, input logic [31:0] w, input logic m,
                            output logic [31:0] res, output int lat);
        int n;
        in_word[d] = w; in_inv[d] = m; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        #1;
        n = 0;
        while (!in_ready[d] && n < 50) begin tick(); n++; end
        tick();
        in_valid[d] = 1'b0; in_word[d] = $urandom; in_inv[d] = !m;
        lat = 0;
        while (!out_valid[d] && lat < 50) begin tick(); lat++; end
        res = out_word[d];
        if (lat >= 50) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d: no out_valid within 50 cycles for word %h", d, w);
        end
        tick();
    endtask

    task automatic test_reset(input int d);
        rst_n[d] = 1'b0;
        tick(); tick();
        rst_n[d] = 1'b1;
        checks++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_word[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out_word=%h, want 1 0 00000000",
                     d, in_ready[d], out_valid[d], out_word[d]);
        end
    endtask

    task automatic test_directed(input int d);
        logic [31:0] w [3] = '{32'h33221100, 32'h7C7C6363, 32'h00000053};
        logic        m [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] e [3] = '{32'hC3938263, 32'h01010000, 32'h636363ED};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_word(d, w[i], m[i], res, lat);
            checks++;
            if (res !== e[i]) begin
                errors++;
                $display("FAIL directed dut%0d #%0d: got %h want %h", d, i, res, e[i]);
            end
            checks++;
            if (lat !== 4 + d) begin
                errors++;
                $display("FAIL latency dut%0d #%0d: got %0d want %0d", d, i, lat, 4 + d);
            end
        end
    endtask

    // Every byte value in every lane, forward then inverse on the forward results.
    task automatic test_exhaustive(input int d);
        logic [31:0] w, res, fwd [256];
        int lat;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(i + 64 * k);
            run_word(d, w, 1'b0, res, lat);
            fwd[i] = res;
            checks++;
            if (res !== model(w, 1'b0)) begin
                errors++;
                $display("FAIL fwd_table dut%0d: in %h got %h want %h", d, w, res, model(w, 1'b0));
            end
        end
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(i + 64 * k);
            run_word(d, fwd[i], 1'b1, res, lat);
            checks++;
            if (res !== w || res !== model(fwd[i], 1'b1)) begin
                errors++;
                $display("FAIL inv_roundtrip dut%0d: in %h got %h want %h", d, fwd[i], res, w);
            end
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] w1, w2, held;
        logic        m1, m2;
        int lat;
        w1 = $urandom; m1 = 1'($urandom_range(0, 1));
        w2 = $urandom; m2 = 1'($urandom_range(0, 1));
        in_word[d] = w1; in_inv[d] = m1; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        #1;
        tick();
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 50) begin tick(); lat++; end
        held = out_word[d];
        checks++;
        if (held !== model(w1, m1)) begin
            errors++;
            $display("FAIL stall_data dut%0d: got %h want %h", d, held, model(w1, m1));
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || out_word[d] !== held) begin
                errors++;
                $display("FAIL stall_hold dut%0d cyc %0d: ov=%b ir=%b ow=%h want 1 0 %h",
                         d, i, out_valid[d], in_ready[d], out_word[d], held);
            end
            tick();
        end
        in_word[d] = w2; in_inv[d] = m2; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        #1;
        checks++;
        if (in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL release_ready dut%0d: in_ready=%b want 1", d, in_ready[d]);
        end
        tick();
        in_valid[d] = 1'b0;
        checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept dut%0d: ov=%b ir=%b want 0 0", d, out_valid[d], in_ready[d]);
        end
        lat = 0;
        while (!out_valid[d] && lat < 50) begin tick(); lat++; end
        checks++;
        if (lat !== 4 + d || out_word[d] !== model(w2, m2)) begin
            errors++;
            $display("FAIL b2b_word dut%0d: lat %0d data %h want %0d %h",
                     d, lat, out_word[d], 4 + d, model(w2, m2));
        end
        tick();
    endtask

    // Random words; with stall=0 valid/ready stay high to measure sustained throughput.
    task automatic test_stream(input int d, input bit stall, input int n);
        logic [31:0] exp_q [$];
        int sent = 0, got = 0, cyc = 0, last = 0;
        logic acc;
        in_valid[d] = 1'b0;
        while (got < n && cyc < 3000) begin
            if (!in_valid[d] && sent < n && (!stall || $urandom_range(0, 1) == 1)) begin
                in_valid[d] = 1'b1; in_word[d] = $urandom; in_inv[d] = 1'($urandom_range(0, 1));
            end
            out_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            acc = in_valid[d] && in_ready[d];
            if (acc) begin exp_q.push_back(model(in_word[d], in_inv[d])); sent++; end
            if (out_valid[d] && out_ready[d]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra dut%0d: unexpected word %h", d, out_word[d]);
                end else begin
                    if (out_word[d] !== exp_q[0]) begin
                        errors++;
                        $display("FAIL stream_data dut%0d: got %h want %h", d, out_word[d], exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
                if (!stall && got > 1) begin
                    checks++;
                    if (cyc - last !== 5 + d) begin
                        errors++;
                        $display("FAIL throughput dut%0d: interval %0d want %0d", d, cyc - last, 5 + d);
                    end
                end
                last = cyc;
            end
            tick();
            cyc++;
            if (acc) begin
                in_valid[d] = 1'b0; in_word[d] = $urandom; in_inv[d] = 1'($urandom_range(0, 1));
            end
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL stream_timeout dut%0d: got %0d of %0d words", d, got, n);
        end
        tick(); tick();
    endtask

    task automatic test_reset_busy(input int d);
        logic [31:0] w, res;
        int lat;
        bit seen = 0;
        w = $urandom;
        in_word[d] = w; in_inv[d] = 1'b0; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        #1;
        tick();
        in_valid[d] = 1'b0;
        tick(); tick();
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        checks++;
        if (out_valid[d] !== 1'b0 || out_word[d] !== 32'h0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL busy_reset dut%0d: ov=%b ow=%h ir=%b want 0 00000000 1",
                     d, out_valid[d], out_word[d], in_ready[d]);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid[d]) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL busy_discard dut%0d: aborted word %h surfaced", d, w);
        end
        w = $urandom;
        run_word(d, w, 1'b1, res, lat);
        checks++;
        if (res !== model(w, 1'b1) || lat !== 4 + d) begin
            errors++;
            $display("FAIL post_reset dut%0d: got %h lat %0d want %h lat %0d",
                     d, res, lat, model(w, 1'b1), 4 + d);
        end
    endtask

    initial begin
        build_model();
        tick();
        for (int d = 0; d < 2; d++) begin
            test_reset(d);
            test_directed(d);
            test_back_to_back(d);
            test_stream(d, 1'b0, 6);
            test_stream(d, 1'b1, 25);
            test_reset_busy(d);
            test_exhaustive(d);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_word_serial.md
SBOX_WORD_SERIAL -- requirements
Module: sbox_word_serial

Interface
REQ-001 Parameter REG_INV, default 1, meaning 1 = register stage after the GF(2^8) inverter, 0 = none.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  producer presents a word.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_word  input  32  four bytes to substitute; byte i = in_word[8i+7:8i].
REQ-007 in_inv  input  1  0 = forward AES S-box, 1 = inverse S-box; sampled with in_word.
REQ-008 out_valid  output  1  out_word holds a complete result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_word  output  32  substituted word; byte i of out_word = S(byte i of in_word), or S^-1 if in_inv.

Function
REQ-011 Accept occurs on a rising edge where in_valid & in_ready; in_word and in_inv SHALL be latched then and later input changes ignored.
REQ-012 One shared datapath SHALL process one byte per cycle, byte 0 first: input basis change, then gf_inv_8, then output basis change.
REQ-013 Forward datapath: A2X basis change, inversion, X2S basis change merged with the affine transform (XOR 0x63).
REQ-014 Inverse datapath: S2X basis change with the inverse affine transform merged (input XOR 0x63 first), inversion, X2A basis change.
REQ-015 Inverter input 0x00 SHALL yield 0x00, giving S(0x00)=0x63 and S^-1(0x63)=0x00.
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready=1; accept -> BUSY with byte counter cleared to 0.
REQ-018 BUSY: in_ready=0; counter (2 bits) increments once per processed byte and wraps 3->0; after the byte-3 result is written -> DONE.
REQ-019 Latency from the accept edge to the first cycle with out_valid=1: 4 cycles if REG_INV=0, 5 cycles if REG_INV=1.
REQ-020 DONE: out_valid=1; out_word SHALL be held stable until a rising edge where out_ready=1.
REQ-021 DONE with out_ready=0: in_ready=0 and the state holds.
REQ-022 DONE with out_ready=1: in_ready=1; an accept on that edge -> BUSY (back-to-back, no IDLE bubble), otherwise -> IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and BUSY; out_word holds its last value outside DONE.
REQ-024 Sustained throughput: one word per 5 cycles (REG_INV=0) or 6 cycles (REG_INV=1).

Reset
REQ-025 rst_n low at a rising edge SHALL force IDLE, counter 0, out_valid 0, out_word 0x00000000 and clear the pipeline register, in any state including BUSY.
REQ-026 A word in flight when reset asserts SHALL be discarded and never appear on out_word.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 Shared package sbox_pkg SHALL hold the four 8x8 GF(2) basis-change matrices (A2X, X2S, S2X, X2A), the 0x63 affine constant, the FSM state enum and the byte-index width.
REQ-029 The block SHALL instantiate the existing gf_inv_8 once as its only sub-module; basis changes are inline XOR networks.

Verification
REQ-030 Forward mode, in_word=0x33221100, out_ready=1 -> out_word=0xC3938263 with out_valid high exactly on the latency cycle from REQ-019.
REQ-031 Inverse mode, in_word=0x7C7C6363 -> out_word=0x01010000; forward mode, in_word=0x00000053 -> out_word=0x636363ED.
REQ-032 Exhaustive test: all 256 byte values in each lane position and both modes match the FIPS-197 tables; S^-1(S(x))=x for every x.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_word stable, in_ready=0; release with in_valid=1 -> back-to-back accept on the same edge.
REQ-034 Pull rst_n low during BUSY byte 2 -> next cycle IDLE, out_valid=0, out_word=0; the next word completes correctly with no stale bytes.
REQ-035 Run REQ-030 to REQ-034 with REG_INV=0 and REG_INV=1 -> identical data, latency differing by exactly 1 cycle.
